// File: rtl/hv_owt_tx_burst_ctrl.sv
// hv_owt_tx_burst_ctrl
// One-wire transmit controller for the HV->LV line. A command accepted on the
// valid/ready handshake is serialised as:
//   Manchester sync head (SYNC_BITS zeros), raw sync tail 1100,
//   Manchester {wr, len, addr}, Manchester data words (writes only),
//   Manchester CRC-8 (poly 0x07, init 0) over cmd+data bits, raw end tail 1100.
// Manchester bit 0 = low,high ; bit 1 = high,low. Each slot lasts SLOT_CYC clocks.
//
// Optional feature macro: HV_OWT_TX_ABORT_EN
//   defined   : i_abort drives the line high for ABORT_SLOTS slots, then o_aborted.
//   undefined : i_abort ignored, o_aborted tied low.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_cmd_vld/o_cmd_rdy  command handshake (rdy = idle and not in reset)
//   i_cmd_wr, i_cmd_addr, i_cmd_len, i_cmd_wdata  command fields, latched at accept
//   i_abort           abort current frame
//   o_owt_tx          registered line level
//   o_busy            frame or abort in progress
//   o_done            one-cycle pulse on normal frame completion
//   o_aborted         one-cycle pulse when the abort sequence finishes
module hv_owt_tx_burst_ctrl #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int MAX_BURST   = 4,
  parameter int SYNC_BITS   = 12,
  parameter int SLOT_CYC    = 12,
  parameter int ABORT_SLOTS = 16,
  localparam int LEN_W      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_cmd_vld,
  output logic                        o_cmd_rdy,
  input  logic                        i_cmd_wr,
  input  logic [ADDR_W-1:0]           i_cmd_addr,
  input  logic [LEN_W-1:0]            i_cmd_len,
  input  logic [MAX_BURST*DATA_W-1:0] i_cmd_wdata,
  input  logic                        i_abort,
  output logic                        o_owt_tx,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_aborted
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CMD_W   = 1 + LEN_W + ADDR_W;
  localparam int BIT_MAX = max2(max2(max2(CMD_W, DATA_W), max2(SYNC_BITS, ABORT_SLOTS)), 8);
  localparam int BIT_W   = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;
  localparam int SLOT_W  = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam int SEL_W   = max2(max2(MAX_BURST * DATA_W, CMD_W), 8);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYC - 1);
  localparam logic [BIT_W-1:0]  SH_LAST   = BIT_W'(SYNC_BITS - 1);
  localparam logic [BIT_W-1:0]  CMD_LAST  = BIT_W'(CMD_W - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  CRC_LAST  = BIT_W'(7);
  localparam logic [BIT_W-1:0]  RAW_LAST  = BIT_W'(3);
`ifdef HV_OWT_TX_ABORT_EN
  localparam logic [BIT_W-1:0]  AB_LAST   = BIT_W'(ABORT_SLOTS - 1);
`endif

  typedef enum logic [2:0] {
    IDLE, SYNC_HEAD, SYNC_TAIL, CMD, DATA, CRC, END_TAIL
`ifdef HV_OWT_TX_ABORT_EN
    , ABORT
`endif
  } state_t;

  // Bit pick by runtime index, done by shifting to keep index widths clean.
  function automatic logic sel_bit(input logic [SEL_W-1:0] v, input int idx);
    logic [SEL_W-1:0] t;
    t = v >> idx;
    return t[0];
  endfunction

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  state_t                      state_q, state_nxt;
  logic [SLOT_W-1:0]           slot_q, slot_nxt;
  logic                        phase_q, phase_nxt;
  logic [BIT_W-1:0]            bit_q, bit_nxt;
  logic [LEN_W-1:0]            word_q, word_nxt;
  logic [7:0]                  crc_q, crc_nxt;
  logic                        tx_q, tx_nxt;
  logic                        done_q, done_nxt;
  logic                        aborted_nxt;
  logic                        accept, slot_end, bit_end, man_state, cur_bit;
  logic [BIT_W-1:0]            man_last;
  logic                        wr_q;
  logic [LEN_W-1:0]            len_q;
  logic [ADDR_W-1:0]           addr_q;
  logic [MAX_BURST*DATA_W-1:0] wdata_q;
  logic [CMD_W-1:0]            cmd_word;

  assign cmd_word  = {wr_q, len_q, addr_q};
  assign o_cmd_rdy = (state_q == IDLE) && !i_rst;
  assign o_busy    = (state_q != IDLE);
  assign o_owt_tx  = tx_q;
  assign o_done    = done_q;

  always_comb begin
    state_nxt   = state_q;
    slot_nxt    = slot_q;
    phase_nxt   = phase_q;
    bit_nxt     = bit_q;
    word_nxt    = word_q;
    crc_nxt     = crc_q;
    done_nxt    = 1'b0;
    aborted_nxt = 1'b0;
    accept      = 1'b0;
    cur_bit     = 1'b0;
    tx_nxt      = 1'b0;
    man_last    = '0;

    case (state_q)
      SYNC_HEAD: man_last = SH_LAST;
      CMD:       man_last = CMD_LAST;
      DATA:      man_last = DATA_LAST;
      CRC:       man_last = CRC_LAST;
      default:   man_last = '0;
    endcase
    man_state = (state_q == SYNC_HEAD) || (state_q == CMD) ||
                (state_q == DATA) || (state_q == CRC);
    slot_end  = (slot_q == SLOT_LAST);
    // A Manchester bit ends after its second half; raw/abort bits are one slot.
    bit_end   = slot_end && (!man_state || phase_q);

    if (state_q != IDLE) begin
      slot_nxt = slot_end ? '0 : slot_q + 1'b1;
      if (slot_end && man_state) phase_nxt = ~phase_q;
      if (bit_end) bit_nxt = bit_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (i_cmd_vld && o_cmd_rdy) begin
          accept    = 1'b1;
          state_nxt = SYNC_HEAD;
          crc_nxt   = 8'h00;
        end
      end
      SYNC_HEAD: if (bit_end && bit_q == man_last) state_nxt = SYNC_TAIL;
      SYNC_TAIL: if (bit_end && bit_q == RAW_LAST) state_nxt = CMD;
      CMD: begin
        cur_bit = sel_bit(SEL_W'(cmd_word), CMD_W - 1 - int'(bit_q));
        if (bit_end) crc_nxt = crc_step(crc_q, cur_bit);
        if (bit_end && bit_q == man_last) state_nxt = wr_q ? DATA : CRC;
      end
      DATA: begin
        cur_bit = sel_bit(SEL_W'(wdata_q), int'(word_q) * DATA_W + DATA_W - 1 - int'(bit_q));
        if (bit_end) crc_nxt = crc_step(crc_q, cur_bit);
        if (bit_end && bit_q == man_last) begin
          if (word_q == len_q) begin
            state_nxt = CRC;
          end else begin
            word_nxt = word_q + 1'b1;
            bit_nxt  = '0;
          end
        end
      end
      CRC: if (bit_end && bit_q == man_last) state_nxt = END_TAIL;
      END_TAIL: begin
        if (bit_end && bit_q == RAW_LAST) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
`ifdef HV_OWT_TX_ABORT_EN
      ABORT: begin
        if (bit_end && bit_q == AB_LAST) begin
          state_nxt   = IDLE;
          aborted_nxt = 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase

`ifdef HV_OWT_TX_ABORT_EN
    // Abort wins over any field transition, including the final tail slot.
    if (i_abort && state_q != IDLE && state_q != ABORT) begin
      state_nxt = ABORT;
      done_nxt  = 1'b0;
    end
`endif

    if (state_nxt != state_q) begin
      slot_nxt  = '0;
      phase_nxt = 1'b0;
      bit_nxt   = '0;
      word_nxt  = '0;
    end

    // The line register is loaded with the level of the position being entered,
    // so the first slot appears the cycle right after accept.
    case (state_nxt)
      SYNC_HEAD: tx_nxt = phase_nxt;
      SYNC_TAIL: tx_nxt = (bit_nxt < 2);
      END_TAIL:  tx_nxt = (bit_nxt < 2);
      CMD:  tx_nxt = sel_bit(SEL_W'(cmd_word), CMD_W - 1 - int'(bit_nxt)) ^ phase_nxt;
      DATA: tx_nxt = sel_bit(SEL_W'(wdata_q),
                             int'(word_nxt) * DATA_W + DATA_W - 1 - int'(bit_nxt)) ^ phase_nxt;
      CRC:  tx_nxt = sel_bit(SEL_W'(crc_nxt), 7 - int'(bit_nxt)) ^ phase_nxt;
`ifdef HV_OWT_TX_ABORT_EN
      ABORT: tx_nxt = 1'b1;
`endif
      default: tx_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      slot_q  <= '0;
      phase_q <= 1'b0;
      bit_q   <= '0;
      word_q  <= '0;
      tx_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      slot_q  <= slot_nxt;
      phase_q <= phase_nxt;
      bit_q   <= bit_nxt;
      word_q  <= word_nxt;
      tx_q    <= tx_nxt;
      done_q  <= done_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    crc_q <= crc_nxt;
    if (accept) begin
      wr_q    <= i_cmd_wr;
      len_q   <= i_cmd_wr ? i_cmd_len : '0;
      addr_q  <= i_cmd_addr;
      wdata_q <= i_cmd_wdata;
    end
  end

`ifdef HV_OWT_TX_ABORT_EN
  logic aborted_q;
  always_ff @(posedge i_clk) begin
    if (i_rst) aborted_q <= 1'b0;
    else       aborted_q <= aborted_nxt;
  end
  assign o_aborted = aborted_q;
`else
  logic unused_abort;
  assign unused_abort = i_abort ^ aborted_nxt;
  assign o_aborted    = 1'b0;
`endif

endmodule

// File: tb/tb_hv_owt_tx_burst_ctrl.sv
// Testbench for hv_owt_tx_burst_ctrl: directed and randomized frames checked
// against a slot-list model built from the frame format rules.
module tb_hv_owt_tx_burst_ctrl;

  localparam int SC     = 12;
  localparam int SB     = 12;
  localparam int AW     = 7;
  localparam int LW     = 2;
  localparam int DW     = 8;
  localparam int MB     = 4;
  localparam int AS     = 16;
  localparam int CMD_W  = 1 + LW + AW;

  logic          clk = 1'b0;
  logic          rst, cmd_vld, cmd_rdy, cmd_wr, abort;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [MB*DW-1:0] cmd_wdata;
  logic          owt_tx, busy, done, aborted;

  int checks   = 0;
  int failures = 0;

  bit exp_q[$];
  int exp_n;

  bit              nxt_pend;
  logic            nxt_wr;
  logic [AW-1:0]   nxt_addr;
  logic [LW-1:0]   nxt_len;
  logic [MB*DW-1:0] nxt_wd;

  always #5 clk = ~clk;

  hv_owt_tx_burst_ctrl dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cmd_vld   (cmd_vld),
    .o_cmd_rdy   (cmd_rdy),
    .i_cmd_wr    (cmd_wr),
    .i_cmd_addr  (cmd_addr),
    .i_cmd_len   (cmd_len),
    .i_cmd_wdata (cmd_wdata),
    .i_abort     (abort),
    .o_owt_tx    (owt_tx),
    .o_busy      (busy),
    .o_done      (done),
    .o_aborted   (aborted)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] crc8(input bit msg[$]);
    logic [7:0] c = 8'h00;
    foreach (msg[i]) begin
      if (c[7] ^ msg[i]) c = (c << 1) ^ 8'h07;
      else               c = c << 1;
    end
    return c;
  endfunction

  function automatic void push_man(input bit b);
    exp_q.push_back(b);
    exp_q.push_back(~b);
  endfunction

  function automatic void push_raw_tail();
    exp_q.push_back(1'b1); exp_q.push_back(1'b1);
    exp_q.push_back(1'b0); exp_q.push_back(1'b0);
  endfunction

  // Expected slot levels for one frame, plus its length by the closed formula.
  function automatic void build(input logic wr, input logic [AW-1:0] addr,
                                input logic [LW-1:0] len, input logic [MB*DW-1:0] wd);
    bit msg[$];
    logic [CMD_W-1:0] cmd;
    logic [7:0] crc;
    int nw;
    exp_q.delete();
    cmd = {wr, (wr ? len : 2'b00), addr};
    for (int i = 0; i < SB; i++) push_man(1'b0);
    push_raw_tail();
    for (int i = CMD_W - 1; i >= 0; i--) msg.push_back(cmd[i]);
    nw = wr ? int'(len) + 1 : 0;
    for (int w = 0; w < nw; w++)
      for (int b = DW - 1; b >= 0; b--) msg.push_back(wd[w*DW + b]);
    foreach (msg[i]) push_man(msg[i]);
    crc = crc8(msg);
    for (int b = 7; b >= 0; b--) push_man(crc[b]);
    push_raw_tail();
    exp_n = 2*SB + 4 + 2*CMD_W + 2*DW*nw + 16 + 4;
  endfunction

  task automatic drive_cmd(input logic wr, input logic [AW-1:0] addr,
                           input logic [LW-1:0] len, input logic [MB*DW-1:0] wd);
    cmd_wr = wr; cmd_addr = addr; cmd_len = len; cmd_wdata = wd; cmd_vld = 1'b1;
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] addr,
                       input logic [LW-1:0] len, input logic [MB*DW-1:0] wd);
    build(wr, addr, len, wd);
    @(negedge clk);
    check_val("rdy_before_accept", 32'(cmd_rdy), 32'd1);
    drive_cmd(wr, addr, len, wd);
    @(posedge clk);
  endtask

  // Checks every cycle after the accept edge; abort_at (cycle index, 0 = none)
  // raises i_abort during that cycle.
  task automatic check_frame(input string nm, input int abort_at);
    int total;
    total = exp_n * SC;
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      check_val({nm, "_tx"},   32'(owt_tx), 32'(exp_q[(k-1)/SC]));
      check_val({nm, "_busy"}, 32'(busy), 32'd1);
      check_val({nm, "_rdy"},  32'(cmd_rdy), 32'd0);
      check_val({nm, "_done"}, 32'(done), 32'd0);
      check_val({nm, "_abpulse"}, 32'(aborted), 32'd0);
      if (k == 1) begin
        if (nxt_pend) begin
          drive_cmd(nxt_wr, nxt_addr, nxt_len, nxt_wd);
          nxt_pend = 1'b0;
        end else begin
          cmd_vld = 1'b0;
        end
      end
      if (abort_at != 0 && k == abort_at + 1) abort = 1'b0;
      if (abort_at != 0 && k == abort_at) begin
        abort = 1'b1;
`ifdef HV_OWT_TX_ABORT_EN
        for (int j = 1; j <= AS*SC; j++) begin
          @(negedge clk);
          if (j == 1) abort = 1'b0;
          check_val({nm, "_ab_tx"},   32'(owt_tx), 32'd1);
          check_val({nm, "_ab_busy"}, 32'(busy), 32'd1);
          check_val({nm, "_ab_done"}, 32'(done), 32'd0);
          check_val({nm, "_ab_early"}, 32'(aborted), 32'd0);
        end
        @(negedge clk);
        check_val({nm, "_aborted"},  32'(aborted), 32'd1);
        check_val({nm, "_ab_nodone"}, 32'(done), 32'd0);
        check_val({nm, "_ab_idle"},  32'(busy), 32'd0);
        check_val({nm, "_ab_rdy"},   32'(cmd_rdy), 32'd1);
        check_val({nm, "_ab_tx0"},   32'(owt_tx), 32'd0);
        return;
`endif
      end
    end
    @(negedge clk);
    check_val({nm, "_done_pulse"}, 32'(done), 32'd1);
    check_val({nm, "_done_busy"},  32'(busy), 32'd0);
    check_val({nm, "_done_rdy"},   32'(cmd_rdy), 32'd1);
    check_val({nm, "_done_tx"},    32'(owt_tx), 32'd0);
    check_val({nm, "_done_ab"},    32'(aborted), 32'd0);
  endtask

  task automatic random_cmd(output logic wr, output logic [AW-1:0] addr,
                            output logic [LW-1:0] len, output logic [MB*DW-1:0] wd);
    wr   = 1'($urandom);
    addr = AW'($urandom);
    len  = LW'($urandom);
    wd   = $urandom;
  endtask

  initial begin
    logic            r_wr;
    logic [AW-1:0]   r_addr;
    logic [LW-1:0]   r_len;
    logic [MB*DW-1:0] r_wd;
    int ka;

    rst = 1'b1; cmd_vld = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    cmd_wdata = '0; abort = 1'b0; nxt_pend = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_rdy", 32'(cmd_rdy), 32'd0);
    check_val("rst_tx", 32'(owt_tx), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_aborted", 32'(aborted), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_rdy", 32'(cmd_rdy), 32'd1);

    // Abort while idle has no effect.
    abort = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_val("idle_abort_busy", 32'(busy), 32'd0);
      check_val("idle_abort_pulse", 32'(aborted), 32'd0);
      check_val("idle_abort_tx", 32'(owt_tx), 32'd0);
    end
    abort = 1'b0;

    issue(1'b0, 7'h00, 2'd0, 32'h0);
    check_frame("read0", 0);

    issue(1'b1, 7'h15, 2'd0, 32'h0000_00A5);
    check_frame("wr_a5", 0);

    issue(1'b1, 7'h2A, 2'd3, 32'h0403_0201);
    check_frame("wr_burst4", 0);

    // Back-to-back: second command waits with vld high and is taken in the done cycle.
    issue(1'b1, 7'h33, 2'd1, 32'h0000_C35A);
    nxt_pend = 1'b1; nxt_wr = 1'b0; nxt_addr = 7'h7F; nxt_len = 2'd3; nxt_wd = 32'hFFFF_FFFF;
    check_frame("b2b_a", 0);
    build(nxt_wr, nxt_addr, nxt_len, nxt_wd);
    check_frame("b2b_b", 0);

    for (int i = 0; i < 6; i++) begin
      random_cmd(r_wr, r_addr, r_len, r_wd);
      issue(r_wr, r_addr, r_len, r_wd);
      check_frame("rand", 0);
    end

    // Abort in the middle of the DATA field of a 4-word write.
    r_wd = $urandom;
    issue(1'b1, 7'($urandom), 2'd3, r_wd);
    ka = (2*SB + 4 + 2*CMD_W) * SC + 1 + int'($urandom_range(0, 64*SC - 2));
    check_frame("abort_data", ka);

    // Abort during CMD, then a normal frame afterwards.
    issue(1'b1, 7'h41, 2'd2, 32'h00BE_EF12);
    ka = (2*SB + 4) * SC + 1 + int'($urandom_range(0, 2*CMD_W*SC - 2));
    check_frame("abort_cmd", ka);
    random_cmd(r_wr, r_addr, r_len, r_wd);
    issue(r_wr, r_addr, r_len, r_wd);
    check_frame("after_abort", 0);

    // Synchronous reset in the middle of CMD.
    issue(1'b1, 7'h5C, 2'd1, 32'h0000_1234);
    ka = (2*SB + 4) * SC + 1 + int'($urandom_range(0, 2*CMD_W*SC - 1));
    for (int k = 1; k <= ka; k++) begin
      @(negedge clk);
      if (k == 1) cmd_vld = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check_val("midrst_tx", 32'(owt_tx), 32'd0);
    check_val("midrst_busy", 32'(busy), 32'd0);
    check_val("midrst_done", 32'(done), 32'd0);
    check_val("midrst_aborted", 32'(aborted), 32'd0);
    check_val("midrst_rdy", 32'(cmd_rdy), 32'd0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_val("postrst_rdy", 32'(cmd_rdy), 32'd1);
      check_val("postrst_busy", 32'(busy), 32'd0);
      check_val("postrst_tx", 32'(owt_tx), 32'd0);
      check_val("postrst_done", 32'(done), 32'd0);
    end

    random_cmd(r_wr, r_addr, r_len, r_wd);
    issue(r_wr, r_addr, r_len, r_wd);
    check_frame("after_rst", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
